// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared Y86-64 definitions for the pipeline: instruction codes, register IDs,
// status codes, and the E pipeline-register record with its bubble value.
// No ports (package).
// -----------------------------------------------------------------------------
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;  // also CMOVXX
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Register IDs
    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    // Status codes
    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    // Contents of the E pipeline register
    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [1:0]  stat;
        logic [63:0] val_c;
        logic [63:0] val_a;
        logic [63:0] val_b;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [3:0]  src_a;
        logic [3:0]  src_b;
    } e_reg_t;

    // A bubble is a NOP that reads and writes nothing
    localparam e_reg_t E_BUBBLE = '{
        icode: I_NOP,   ifun: 4'h0,    stat: STAT_AOK,
        val_c: 64'd0,   val_a: 64'd0,  val_b: 64'd0,
        dst_e: RNONE,   dst_m: RNONE,  src_a: RNONE, src_b: RNONE
    };

endpackage

// File: rtl/decode_module_if.sv
// -----------------------------------------------------------------------------
// decode_module_if
// Bundles the decode stage's pipeline-facing signals:
//   D_*            D-register fields (from fetch)
//   e_/M_/m_/W_*   forwarding destination IDs and values from later stages
//   regfile        architectural registers 0..14, reg i at [64*i+63:64*i]
//   E_bubble       bubble request from pipeline control
//   d_*            combinational source IDs / forwarded operands
//   E_*            E pipeline-register outputs
// master: the surrounding pipeline; slave: the decode stage.
// -----------------------------------------------------------------------------
interface decode_module_if;

    logic [3:0]   D_icode, D_ifun, D_rA, D_rB;
    logic [63:0]  D_valC, D_valP;
    logic [1:0]   D_stat;

    logic [3:0]   e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0]  e_valE, M_valE, m_valM, W_valE, W_valM;

    logic [959:0] regfile;
    logic         E_bubble;

    logic [3:0]   d_srcA, d_srcB;
    logic [63:0]  d_valA, d_valB;

    logic [3:0]   E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM;
    logic [63:0]  E_valA, E_valB, E_valC;
    logic [1:0]   E_stat;

    modport master (
        output D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat,
        output e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
        output e_valE, M_valE, m_valM, W_valE, W_valM,
        output regfile, E_bubble,
        input  d_srcA, d_srcB, d_valA, d_valB,
        input  E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM,
        input  E_valA, E_valB, E_valC, E_stat
    );

    modport slave (
        input  D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat,
        input  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
        input  e_valE, M_valE, m_valM, W_valE, W_valM,
        input  regfile, E_bubble,
        output d_srcA, d_srcB, d_valA, d_valB,
        output E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM,
        output E_valA, E_valB, E_valC, E_stat
    );

endinterface

// File: rtl/decode_module_fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
// One operand of the decode stage: five-source priority forwarding in front of
// a register-file read, with an optional valP override (used for jXX/call).
//   i_src        source register ID (RNONE = no read, yields 0)
//   i_use_valp   select i_valp ahead of everything else
//   i_valp       fall-through PC
//   i_*_dst*     forwarding destination IDs, i_*_val* their values
//   i_regfile    registers 0..14 packed 64 bits each
//   o_val        selected operand
// -----------------------------------------------------------------------------
module fwd_sel
    import y86_pkg::*;
(
    input  logic [3:0]   i_src,
    input  logic         i_use_valp,
    input  logic [63:0]  i_valp,
    input  logic [3:0]   i_e_dste,
    input  logic [63:0]  i_e_vale,
    input  logic [3:0]   i_m_dstm,
    input  logic [63:0]  i_m_valm,
    input  logic [3:0]   i_m_dste,
    input  logic [63:0]  i_m_vale,
    input  logic [3:0]   i_w_dstm,
    input  logic [63:0]  i_w_valm,
    input  logic [3:0]   i_w_dste,
    input  logic [63:0]  i_w_vale,
    input  logic [959:0] i_regfile,
    output logic [63:0]  o_val
);

    // RNONE must never hit a forwarding source even if a stage carries RNONE
    logic w_live;
    assign w_live = (i_src != RNONE);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can
        // leave it unassigned and infer a latch.
        o_val = 64'd0;
        if (i_use_valp)                          o_val = i_valp;
        else if (w_live && i_src == i_e_dste)    o_val = i_e_vale;
        else if (w_live && i_src == i_m_dstm)    o_val = i_m_valm;
        else if (w_live && i_src == i_m_dste)    o_val = i_m_vale;
        else if (w_live && i_src == i_w_dstm)    o_val = i_w_valm;
        else if (w_live && i_src == i_w_dste)    o_val = i_w_vale;
        else if (w_live)                         o_val = i_regfile[{i_src, 6'd0} +: 64];
    end

endmodule

// File: rtl/decode_module.sv
// -----------------------------------------------------------------------------
// decode_module
// Y86-64 decode / write-back-read stage. Derives source/destination register
// IDs from the D register, reads forwarded operands, and loads the E pipeline
// register every cycle (bubble on E_bubble or reset).
//   clk   stage clock, rising edge
//   rst   asynchronous active-high reset; E register goes to bubble at once
//   bus   decode_module_if.slave (D inputs, forwarding, regfile, d_*/E_* out)
// -----------------------------------------------------------------------------
module decode_module
    import y86_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    decode_module_if.slave bus
);

    logic [3:0]  w_src_a, w_src_b, w_dst_e, w_dst_m;
    logic [63:0] w_val_a, w_val_b;
    logic        w_use_valp;
    e_reg_t      r_e;

    // Register ID selection. The cmov condition is resolved in execute, so
    // rrmovq/cmovXX always names rB here. Invalid icodes fall to RNONE.
    always_comb begin
        w_src_a = RNONE;
        w_src_b = RNONE;
        w_dst_e = RNONE;
        w_dst_m = RNONE;
        case (bus.D_icode)
            I_RRMOVQ: begin w_src_a = bus.D_rA; w_dst_e = bus.D_rB; end
            I_IRMOVQ: begin w_dst_e = bus.D_rB; end
            I_RMMOVQ: begin w_src_a = bus.D_rA; w_src_b = bus.D_rB; end
            I_MRMOVQ: begin w_src_b = bus.D_rB; w_dst_m = bus.D_rA; end
            I_OPQ:    begin w_src_a = bus.D_rA; w_src_b = bus.D_rB; w_dst_e = bus.D_rB; end
            I_CALL:   begin w_src_b = RSP; w_dst_e = RSP; end
            I_RET:    begin w_src_a = RSP; w_src_b = RSP; w_dst_e = RSP; end
            I_PUSHQ:  begin w_src_a = bus.D_rA; w_src_b = RSP; w_dst_e = RSP; end
            I_POPQ:   begin w_src_a = RSP; w_src_b = RSP; w_dst_e = RSP; w_dst_m = bus.D_rA; end
            default:  ;
        endcase
    end

    // jXX and call carry valP down the pipe in valA (branch-fallthrough / return address)
    assign w_use_valp = (bus.D_icode == I_JXX) || (bus.D_icode == I_CALL);

    fwd_sel u_fwd_a (
        .i_src      (w_src_a),
        .i_use_valp (w_use_valp),
        .i_valp     (bus.D_valP),
        .i_e_dste   (bus.e_dstE),
        .i_e_vale   (bus.e_valE),
        .i_m_dstm   (bus.M_dstM),
        .i_m_valm   (bus.m_valM),
        .i_m_dste   (bus.M_dstE),
        .i_m_vale   (bus.M_valE),
        .i_w_dstm   (bus.W_dstM),
        .i_w_valm   (bus.W_valM),
        .i_w_dste   (bus.W_dstE),
        .i_w_vale   (bus.W_valE),
        .i_regfile  (bus.regfile),
        .o_val      (w_val_a)
    );

    fwd_sel u_fwd_b (
        .i_src      (w_src_b),
        .i_use_valp (1'b0),
        .i_valp     (64'd0),
        .i_e_dste   (bus.e_dstE),
        .i_e_vale   (bus.e_valE),
        .i_m_dstm   (bus.M_dstM),
        .i_m_valm   (bus.m_valM),
        .i_m_dste   (bus.M_dstE),
        .i_m_vale   (bus.M_valE),
        .i_w_dstm   (bus.W_dstM),
        .i_w_valm   (bus.W_valM),
        .i_w_dste   (bus.W_dstE),
        .i_w_vale   (bus.W_valE),
        .i_regfile  (bus.regfile),
        .o_val      (w_val_b)
    );

    // E pipeline register: no stall, so it loads every edge.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_e <= E_BUBBLE;
        end else if (bus.E_bubble) begin
            r_e <= E_BUBBLE;
        end else begin
            r_e <= '{
                icode: bus.D_icode, ifun: bus.D_ifun, stat: bus.D_stat,
                val_c: bus.D_valC,  val_a: w_val_a,   val_b: w_val_b,
                dst_e: w_dst_e,     dst_m: w_dst_m,   src_a: w_src_a, src_b: w_src_b
            };
        end
    end

    assign bus.d_srcA  = w_src_a;
    assign bus.d_srcB  = w_src_b;
    assign bus.d_valA  = w_val_a;
    assign bus.d_valB  = w_val_b;

    assign bus.E_icode = r_e.icode;
    assign bus.E_ifun  = r_e.ifun;
    assign bus.E_stat  = r_e.stat;
    assign bus.E_valC  = r_e.val_c;
    assign bus.E_valA  = r_e.val_a;
    assign bus.E_valB  = r_e.val_b;
    assign bus.E_dstE  = r_e.dst_e;
    assign bus.E_dstM  = r_e.dst_m;
    assign bus.E_srcA  = r_e.src_a;
    assign bus.E_srcB  = r_e.src_b;

endmodule

// File: tb/tb_decode_module.sv
// -----------------------------------------------------------------------------
// tb_decode_module
// Directed scenarios followed by randomized instructions, checked against a
// behavioural model of the Y86-64 decode rules kept in this file.
// -----------------------------------------------------------------------------
module tb_decode_module;
    import y86_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_module_if bus ();

    decode_module u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [63:0] regs [15];
    int          n_pass  = 0;
    int          n_total = 0;
    e_reg_t      exp_e;

    // ------------------------------------------------------------------ checks
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // -------------------------------------------------------- reference model
    function automatic bit in_set(input logic [3:0] ic, input logic [3:0] set_q[$]);
        foreach (set_q[i]) if (set_q[i] == ic) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] ref_src_a(input logic [3:0] ic, input logic [3:0] ra);
        if (in_set(ic, '{4'h2, 4'h4, 4'h6, 4'hA})) return ra;
        if (in_set(ic, '{4'h9, 4'hB}))             return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] ref_src_b(input logic [3:0] ic, input logic [3:0] rb);
        if (in_set(ic, '{4'h4, 4'h5, 4'h6}))       return rb;
        if (in_set(ic, '{4'h8, 4'h9, 4'hA, 4'hB})) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] ref_dst_e(input logic [3:0] ic, input logic [3:0] rb);
        if (in_set(ic, '{4'h2, 4'h3, 4'h6}))       return rb;
        if (in_set(ic, '{4'h8, 4'h9, 4'hA, 4'hB})) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] ref_dst_m(input logic [3:0] ic, input logic [3:0] ra);
        if (in_set(ic, '{4'h5, 4'hB})) return ra;
        return 4'hF;
    endfunction

    // Forwarding sources listed youngest first; first live match wins.
    function automatic logic [63:0] ref_read(input logic [3:0] id);
        logic [3:0]  ids  [5];
        logic [63:0] vals [5];
        ids  = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
        vals = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
        if (id == 4'hF) return 64'd0;
        for (int i = 0; i < 5; i++) if (ids[i] == id) return vals[i];
        return regs[id];
    endfunction

    // ---------------------------------------------------------------- helpers
    task automatic load_rf();
        for (int i = 0; i < 15; i++) bus.regfile[64*i +: 64] = regs[i];
    endtask

    task automatic clear_fwd();
        bus.e_dstE = 4'hF; bus.M_dstE = 4'hF; bus.M_dstM = 4'hF;
        bus.W_dstE = 4'hF; bus.W_dstM = 4'hF;
        bus.e_valE = 64'd0; bus.M_valE = 64'd0; bus.m_valM = 64'd0;
        bus.W_valE = 64'd0; bus.W_valM = 64'd0;
    endtask

    task automatic set_d(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                         input logic [1:0] st);
        bus.D_icode = ic; bus.D_ifun = fn; bus.D_rA = ra; bus.D_rB = rb;
        bus.D_valC = vc;  bus.D_valP = vp; bus.D_stat = st;
    endtask

    // Settle, compare combinational outputs against the model, and record the
    // E-register contents the model expects after the next edge.
    task automatic check_decode(input string tag);
        logic [3:0]  sa, sb;
        logic [63:0] va, vb;
        #1;
        sa = ref_src_a(bus.D_icode, bus.D_rA);
        sb = ref_src_b(bus.D_icode, bus.D_rB);
        va = (bus.D_icode == 4'h7 || bus.D_icode == 4'h8) ? bus.D_valP : ref_read(sa);
        vb = ref_read(sb);
        check({tag, ".d_srcA"}, bus.d_srcA, sa);
        check({tag, ".d_srcB"}, bus.d_srcB, sb);
        check({tag, ".d_valA"}, bus.d_valA, va);
        check({tag, ".d_valB"}, bus.d_valB, vb);
        if (bus.E_bubble)
            exp_e = '{icode: 4'h1, ifun: 4'h0, stat: 2'd0, val_c: 64'd0, val_a: 64'd0,
                      val_b: 64'd0, dst_e: 4'hF, dst_m: 4'hF, src_a: 4'hF, src_b: 4'hF};
        else
            exp_e = '{icode: bus.D_icode, ifun: bus.D_ifun, stat: bus.D_stat,
                      val_c: bus.D_valC, val_a: va, val_b: vb,
                      dst_e: ref_dst_e(bus.D_icode, bus.D_rB),
                      dst_m: ref_dst_m(bus.D_icode, bus.D_rA), src_a: sa, src_b: sb};
    endtask

    task automatic check_e(input string tag, input e_reg_t e);
        check({tag, ".E_icode"}, bus.E_icode, e.icode);
        check({tag, ".E_ifun"},  bus.E_ifun,  e.ifun);
        check({tag, ".E_stat"},  bus.E_stat,  e.stat);
        check({tag, ".E_valC"},  bus.E_valC,  e.val_c);
        check({tag, ".E_valA"},  bus.E_valA,  e.val_a);
        check({tag, ".E_valB"},  bus.E_valB,  e.val_b);
        check({tag, ".E_dstE"},  bus.E_dstE,  e.dst_e);
        check({tag, ".E_dstM"},  bus.E_dstM,  e.dst_m);
        check({tag, ".E_srcA"},  bus.E_srcA,  e.src_a);
        check({tag, ".E_srcB"},  bus.E_srcB,  e.src_b);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        check_e(tag, exp_e);
    endtask

    function automatic logic [3:0] rnd_id();
        int r;
        r = $urandom_range(0, 5);
        return (r == 5) ? 4'hF : 4'(r);
    endfunction

    localparam e_reg_t BUBBLE_REF = '{icode: 4'h1, ifun: 4'h0, stat: 2'd0, val_c: 64'd0,
                                      val_a: 64'd0, val_b: 64'd0, dst_e: 4'hF,
                                      dst_m: 4'hF, src_a: 4'hF, src_b: 4'hF};

    // -------------------------------------------------------------- stimulus
    initial begin
        rst = 1'b1;
        bus.E_bubble = 1'b0;
        set_d(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 2'd0);
        clear_fwd();
        for (int i = 0; i < 15; i++) regs[i] = 64'd0;
        load_rf();
        #2;
        check_e("reset", BUBBLE_REF);
        @(negedge clk);
        rst = 1'b0;

        // addq %rax,%rbx with no hazards
        regs[0] = 64'd5; regs[3] = 64'd7; load_rf();
        set_d(4'h6, 4'h0, 4'h0, 4'h3, 64'd0, 64'd0, 2'd0);
        check_decode("opq");
        check("opq.valA_const", bus.d_valA, 64'd5);
        check("opq.valB_const", bus.d_valB, 64'd7);
        step("opq");
        check("opq.E_dstE_const", bus.E_dstE, 64'd3);
        check("opq.E_dstM_const", bus.E_dstM, 64'hF);

        // Forwarding priority on srcA=2
        set_d(4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'd0, 2'd0);
        bus.e_dstE = 4'h2; bus.e_valE = 64'd11;
        bus.M_dstM = 4'h2; bus.m_valM = 64'd22;
        check_decode("fwd_e");
        check("fwd_e.const", bus.d_valA, 64'd11);
        bus.e_dstE = 4'hF;
        check_decode("fwd_m");
        check("fwd_m.const", bus.d_valA, 64'd22);
        bus.M_dstM = 4'hF; bus.W_dstE = 4'h2; bus.W_valE = 64'd33;
        check_decode("fwd_w");
        check("fwd_w.const", bus.d_valA, 64'd33);
        step("fwd_w");
        clear_fwd();

        // call: valA = valP, rsp forwarded from M
        regs[4] = 64'd8192; load_rf();
        set_d(4'h8, 4'h0, 4'hF, 4'hF, 64'h1000, 64'h40, 2'd0);
        bus.M_dstE = 4'h4; bus.M_valE = 64'd8184;
        check_decode("call");
        check("call.valA_const", bus.d_valA, 64'h40);
        check("call.valB_const", bus.d_valB, 64'd8184);
        step("call");
        check("call.E_dstE_const", bus.E_dstE, 64'd4);
        clear_fwd();

        // popq %rcx
        set_d(4'hB, 4'h0, 4'h1, 4'hF, 64'd0, 64'd0, 2'd0);
        check_decode("popq");
        check("popq.srcA_const", bus.d_srcA, 64'd4);
        check("popq.srcB_const", bus.d_srcB, 64'd4);
        step("popq");
        check("popq.E_dstM_const", bus.E_dstM, 64'd1);
        check("popq.E_dstE_const", bus.E_dstE, 64'd4);

        // Bubble during irmovq, then irmovq $100,%rbp loads normally
        set_d(4'h3, 4'h0, 4'hF, 4'h5, 64'd100, 64'd10, 2'd0);
        bus.E_bubble = 1'b1;
        check_decode("bubble");
        step("bubble");
        bus.E_bubble = 1'b0;
        check_decode("irmovq");
        step("irmovq");
        check("irmovq.E_icode_const", bus.E_icode, 64'd3);
        check("irmovq.E_dstE_const",  bus.E_dstE,  64'd5);
        check("irmovq.E_valC_const",  bus.E_valC,  64'd100);

        // Reset mid-cycle clears E without an edge, and dominates over a load
        #2;
        rst = 1'b1;
        #1;
        check_e("rst_async", BUBBLE_REF);
        bus.E_bubble = 1'b0;
        @(posedge clk);
        #1;
        check_e("rst_hold", BUBBLE_REF);
        @(negedge clk);
        rst = 1'b0;

        // Invalid icode: no register IDs, status passes through
        set_d(4'hC, 4'h5, 4'h1, 4'h2, 64'd9, 64'd8, 2'd3);
        check_decode("invalid");
        check("invalid.srcA_const", bus.d_srcA, 64'hF);
        step("invalid");
        check("invalid.E_stat_const", bus.E_stat, 64'd3);

        // Randomized instructions against the model
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 15; i++) regs[i] = {$urandom, $urandom};
            load_rf();
            set_d(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 0) ? rnd_id() : 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 0) ? rnd_id() : 4'($urandom_range(0, 15)),
                  {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
            bus.e_dstE = rnd_id(); bus.M_dstE = rnd_id(); bus.M_dstM = rnd_id();
            bus.W_dstE = rnd_id(); bus.W_dstM = rnd_id();
            bus.e_valE = {$urandom, $urandom}; bus.M_valE = {$urandom, $urandom};
            bus.m_valM = {$urandom, $urandom}; bus.W_valE = {$urandom, $urandom};
            bus.W_valM = {$urandom, $urandom};
            bus.E_bubble = ($urandom_range(0, 7) == 0);
            check_decode("rand");
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
